axis_bram_reader: RTL and testbench
===================================

Name: axis_bram_reader

Overview:
Read-side companion to the DAQ capture block. It reads captured 16-bit samples from BRAM port B and streams them out as an AXI-Stream master, typically toward a DMA/FIFO for the ARM. Readout starts on a software enable. It ends at a programmed length, or earlier on the 0x7FFF end-of-sequence delimiter that the capture path writes.

Parameters:
AXIS_TDATA_WIDTH, 32, output stream width; the sample is sign-extended into it.
BRAM_DATA_WIDTH, 16, BRAM word width.
BRAM_ADDR_WIDTH, 16, BRAM address width; the maximum readout is 2^BRAM_ADDR_WIDTH words.
DELIMITER, 16'h7FFF, end-of-sequence marker.

Ports:
aclk  in  1  system clock; all logic is on the rising edge.
areset  in  1  asynchronous, active-high reset.
rd_control  in  32  [31:16] length (0 means 2^BRAM_ADDR_WIDTH); [1] stop_on_delim; [0] enable.
rd_status  out  32  [31:16] words_sent; [15:2] zero; [1] busy; [0] done.
bram_portb_clk  out  1  equals aclk.
bram_portb_addr  out  BRAM_ADDR_WIDTH  read address.
bram_portb_rddata  in  BRAM_DATA_WIDTH  read data, valid 1 cycle after bram_portb_en.
bram_portb_en  out  1  read enable.
m_axis_tdata  out  AXIS_TDATA_WIDTH  sign-extended sample.
m_axis_tvalid  out  1  AXI-Stream valid.
m_axis_tready  in  1  AXI-Stream ready.
m_axis_tlast  out  1  final beat of the readout.

Behaviour:
- Reset (async, any state): FSM to IDLE; addr=0, en=0, tvalid=0, tlast=0, words_sent=0, busy=0, done=0; the skid buffer is emptied.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: addr=0. When enable=1, latch length and stop_on_delim, clear words_sent, then go to READ.
- READ:
  - Issue en=1 when (in-flight reads + skid occupancy) < 2, then increment addr.
  - Issue exactly `length` reads.
  - After the last read is issued, go to DRAIN.
- DRAIN: issue no new reads; go to DONE after the last beat handshakes.
- DONE:
  - done=1, busy=0.
  - Hold DONE while enable=1; when enable=0, go to IDLE.
  - Re-arming therefore needs enable to fall and rise again.
- busy=1 in READ and DRAIN.
- enable dropping in READ or DRAIN is ignored; the readout always completes, so tvalid is never retracted.
- Data path:
  - BRAM latency is 1 cycle. Returned words go into a 2-entry skid FIFO that drives m_axis_*.
  - tdata = sign-extend(rddata).
  - Throughput is 1 beat/cycle when tready is held high.
  - Latency: first tvalid appears 2 cycles after the IDLE->READ transition.
- Handshake:
  - A beat transfers on tvalid & tready.
  - tdata, tlast and tvalid stay stable while tvalid=1 and tready=0.
  - words_sent increments per transfer and saturates at 0xFFFF.
- tlast is set on the beat carrying word index length-1.
- Delimiter:
  - Applies when stop_on_delim=1 and the returned word equals DELIMITER.
  - That word is sent with tlast=1.
  - Any already-fetched words behind it are discarded.
  - No further reads are issued; the FSM goes to DRAIN.
- Delimiter in the last word: a single tlast, no double counting.
- Address counter:
  - length=0 reads the full space; the final address is 2^BRAM_ADDR_WIDTH-1.
  - The counter wraps to 0 but issues no extra read.
- Arithmetic: the internal read counter is BRAM_ADDR_WIDTH+1 bits wide so the full-space case is representable.

Decomposition:
- Package axis_daq_pkg: DELIMITER constant, FSM state encoding, rd_control/rd_status field bit positions (shared with the capture block).
- Sub-module axis_skid_fifo2: 2-entry AXI-Stream buffer (tdata + tlast) with an occupancy output and a flush input.

Test Plan:
1. BRAM[i]=i for i=0..7, length=8, stop_on_delim=0, tready=1, enable=1 -> 8 beats with tdata 0..7 on consecutive cycles; tlast only on tdata=7; done=1; words_sent=8.
2. Same as 1, tready toggling 1010... -> identical data order; tdata is stable while stalled; no loss or duplicates; en never leaves more than 2 words outstanding.
3. BRAM[0..3]={0x0001, 0x8000, 0x7FFF, 0x0005}, length=16, stop_on_delim=1 -> beats 0x00000001, 0xFFFF8000, 0x00007FFF (tlast); words_sent=3; no read past addr 3 plus the in-flight prefetch.
4. length=0, BRAM_ADDR_WIDTH=4 -> 16 beats; tlast on address 15; FSM goes to DONE; no 17th read.
5. Drop enable mid-READ -> transfer completes; DONE is reached and then IDLE on the next cycle; re-raising enable starts a new readout from addr 0.
6. Assert areset mid-READ with tvalid=1 -> tvalid, en, busy and done are 0 immediately, before the next aclk edge; state is IDLE after release.

Source files
------------

// File: rtl/axis_daq_pkg.sv
// ---------------------------------------------------------------------------
// axis_daq_pkg
// Shared definitions for the DAQ capture/readout blocks:
//   - DAQ_DELIMITER     : end-of-sequence word written by the capture path
//   - rd_state_e        : readout FSM encoding (also the debug view of state)
//   - CTRL_* / STAT_*   : bit positions inside rd_control / rd_status
//   - sat_inc16()       : saturating 16-bit increment used by word counters
// ---------------------------------------------------------------------------
package axis_daq_pkg;

  localparam logic [15:0] DAQ_DELIMITER = 16'h7FFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  // rd_control fields
  localparam int CTRL_ENABLE_BIT     = 0;
  localparam int CTRL_STOP_DELIM_BIT = 1;
  localparam int CTRL_LEN_LSB        = 16;
  localparam int CTRL_LEN_WIDTH      = 16;

  // rd_status fields
  localparam int STAT_DONE_BIT   = 0;
  localparam int STAT_BUSY_BIT   = 1;
  localparam int STAT_WORDS_LSB  = 16;
  localparam int STAT_WORDS_WIDTH = 16;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axis_skid_fifo2.sv
// ---------------------------------------------------------------------------
// axis_skid_fifo2
// Two-entry AXI-Stream output buffer carrying tdata + tlast.
//
// Ports:
//   aclk, areset        clock, asynchronous active-high reset (empties buffer)
//   flush               synchronous empty request
//   push, push_data,
//   push_last           write side; caller guarantees push never arrives
//                       while the buffer is full and not popping
//   m_tdata, m_tvalid,
//   m_tready, m_tlast   AXI-Stream master side
//   occupancy           number of stored entries (0..2)
//
// Handshake: a beat transfers on a rising edge where m_tvalid & m_tready are
// both 1. While m_tvalid=1 and m_tready=0 the head entry (tdata/tlast) is
// held unchanged and m_tvalid is never withdrawn.
// ---------------------------------------------------------------------------
module axis_skid_fifo2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;
  logic [DATA_WIDTH-1:0] tail_data;
  logic                  tail_last;
  logic [1:0]            occ;
  logic                  pop;

  assign pop = (occ != 2'd0) && m_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      occ       <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else if (flush) begin
      occ <= 2'd0;
    end else begin
      occ <= occ + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        if (occ == 2'd2) begin
          // Tail slides forward; a simultaneous push refills the tail.
          head_data <= tail_data;
          head_last <= tail_last;
          if (push) begin
            tail_data <= push_data;
            tail_last <= push_last;
          end
        end else if (push) begin
          // Single entry leaving while a new one arrives: pass straight to head.
          head_data <= push_data;
          head_last <= push_last;
        end
      end else if (push) begin
        if (occ == 2'd0) begin
          head_data <= push_data;
          head_last <= push_last;
        end else begin
          tail_data <= push_data;
          tail_last <= push_last;
        end
      end
    end
  end

  assign m_tdata   = head_data;
  assign m_tlast   = head_last;
  assign m_tvalid  = (occ != 2'd0);
  assign occupancy = occ;

endmodule

// File: rtl/axis_bram_reader.sv
// ---------------------------------------------------------------------------
// axis_bram_reader
// Streams captured samples from BRAM port B out as an AXI-Stream master.
// A rising software enable starts a readout of `length` words (0 = whole
// address space); with stop_on_delim set, the readout also ends on the first
// DELIMITER word, which is sent as the final (tlast) beat.
//
// Ports:
//   aclk, areset        clock, asynchronous active-high reset
//   rd_control          [31:16] length, [1] stop_on_delim, [0] enable
//   rd_status           [31:16] words_sent, [1] busy, [0] done
//   bram_portb_*        BRAM read port (1-cycle read latency)
//   m_axis_*            AXI-Stream master (sign-extended samples)
//
// Handshake: a beat transfers on a rising edge where tvalid & tready are 1;
// tdata/tlast/tvalid hold while tvalid=1 and tready=0.
//
// Samples are buffered in a 2-entry skid FIFO. A read is issued only when
// the words already committed (data returning this cycle + FIFO entries,
// less the beat leaving this cycle) leave room, so the FIFO never overflows
// yet sustains one beat per cycle under continuous tready.
// AXIS_TDATA_WIDTH must exceed BRAM_DATA_WIDTH.
// ---------------------------------------------------------------------------
module axis_bram_reader
  import axis_daq_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 16,
  parameter int BRAM_ADDR_WIDTH  = 16,
  parameter logic [BRAM_DATA_WIDTH-1:0] DELIMITER = BRAM_DATA_WIDTH'(DAQ_DELIMITER)
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [31:0]                 rd_control,
  output logic [31:0]                 rd_status,
  output logic                        bram_portb_clk,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_portb_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]  bram_portb_rddata,
  output logic                        bram_portb_en,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast
);

  localparam int AW = BRAM_ADDR_WIDTH;
  // Only the length bits that fit the address space are meaningful.
  localparam int LW = (AW < CTRL_LEN_WIDTH) ? AW : CTRL_LEN_WIDTH;
  localparam logic [AW:0] FULL_LEN = {1'b1, {AW{1'b0}}};

  rd_state_e        state;
  logic [AW:0]      len_q;
  logic [AW:0]      issued_q;
  logic [AW-1:0]    addr_q;
  logic             stop_q;
  logic             busy_q;
  logic             done_q;
  logic [15:0]      words_sent_q;
  logic             pend_q;       // a read was issued last cycle; data is on rddata now
  logic             pend_last_q;  // ...and it was the final read of the readout

  logic             enable;
  logic             stop_req;
  logic [LW-1:0]    len_field;
  logic [AW:0]      len_req;
  logic             ctrl_unused;

  logic             beat_fire;
  logic             delim_hit;
  logic             rd_issue;
  logic             last_issue;
  logic [2:0]       slots_used;
  logic [2:0]       slots_limit;
  logic [1:0]       fifo_occ;
  logic             fifo_flush;
  logic [AXIS_TDATA_WIDTH-1:0] push_data;
  logic             push_last;

  // ---------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------
  assign enable    = rd_control[CTRL_ENABLE_BIT];
  assign stop_req  = rd_control[CTRL_STOP_DELIM_BIT];
  assign len_field = rd_control[CTRL_LEN_LSB +: LW];
  assign len_req   = (len_field == '0) ? FULL_LEN
                                       : {{(AW + 1 - LW){1'b0}}, len_field};
  assign ctrl_unused = ^rd_control;

  // ---------------------------------------------------------------------
  // Read issue
  // ---------------------------------------------------------------------
  assign beat_fire   = m_axis_tvalid && m_axis_tready;
  assign delim_hit   = pend_q && stop_q && (bram_portb_rddata == DELIMITER);
  assign slots_used  = {2'b00, pend_q} + {1'b0, fifo_occ};
  assign slots_limit = 3'd2 + {2'b00, beat_fire};
  assign last_issue  = ((issued_q + (AW + 1)'(1)) == len_q);

  // Holding off the read in the delimiter cycle means nothing is ever
  // fetched behind the delimiter, so no buffered words need discarding.
  assign rd_issue = (state == ST_READ) && !delim_hit && (slots_used < slots_limit);

  // ---------------------------------------------------------------------
  // Readout FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state        <= ST_IDLE;
      len_q        <= '0;
      issued_q     <= '0;
      addr_q       <= '0;
      stop_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      words_sent_q <= '0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
    end else begin
      pend_q      <= rd_issue;
      pend_last_q <= rd_issue && last_issue;

      if (beat_fire) begin
        words_sent_q <= sat_inc16(words_sent_q);
      end

      if (rd_issue) begin
        // In the full-space case the address wraps to 0 on the final issue.
        addr_q   <= addr_q + AW'(1);
        issued_q <= issued_q + (AW + 1)'(1);
      end

      case (state)
        ST_IDLE: begin
          addr_q <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (enable) begin
            len_q        <= len_req;
            stop_q       <= stop_req;
            words_sent_q <= '0;
            issued_q     <= '0;
            busy_q       <= 1'b1;
            state        <= ST_READ;
          end
        end

        // enable is deliberately ignored until the readout finishes.
        ST_READ: begin
          if (delim_hit || (rd_issue && last_issue)) begin
            state <= ST_DRAIN;
          end
        end

        // The tlast beat is the last word in the pipeline by construction.
        ST_DRAIN: begin
          if (beat_fire && m_axis_tlast) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end
        end

        // Re-arming requires enable to fall first.
        ST_DONE: begin
          if (!enable) begin
            done_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Data path
  // ---------------------------------------------------------------------
  assign push_data  = {{(AXIS_TDATA_WIDTH - BRAM_DATA_WIDTH){bram_portb_rddata[BRAM_DATA_WIDTH-1]}},
                       bram_portb_rddata};
  // A delimiter landing on the final word still yields one tlast beat.
  assign push_last  = pend_last_q || delim_hit;
  assign fifo_flush = (state == ST_IDLE);

  axis_skid_fifo2 #(
    .DATA_WIDTH (AXIS_TDATA_WIDTH)
  ) u_skid (
    .aclk      (aclk),
    .areset    (areset),
    .flush     (fifo_flush),
    .push      (pend_q),
    .push_data (push_data),
    .push_last (push_last),
    .m_tdata   (m_axis_tdata),
    .m_tvalid  (m_axis_tvalid),
    .m_tready  (m_axis_tready),
    .m_tlast   (m_axis_tlast),
    .occupancy (fifo_occ)
  );

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bram_portb_clk  = aclk;
  assign bram_portb_addr = addr_q;
  assign bram_portb_en   = rd_issue;

  always_comb begin
    rd_status = '0;
    rd_status[STAT_WORDS_LSB +: STAT_WORDS_WIDTH] = words_sent_q;
    rd_status[STAT_BUSY_BIT] = busy_q;
    rd_status[STAT_DONE_BIT] = done_q;
  end

endmodule

// File: tb/tb_axis_bram_reader.sv
// ---------------------------------------------------------------------------
// tb_axis_bram_reader
// Directed bench for axis_bram_reader with a 16-word BRAM model
// (BRAM_ADDR_WIDTH=4). A passive monitor records accepted beats and read
// activity; each test task builds its expected beat queue and compares.
// ---------------------------------------------------------------------------
module tb_axis_bram_reader;

  localparam int TW = 32;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int BW = TW + 1;  // {tlast, tdata}

  // clock / reset
  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic [31:0]   rd_control;
  logic [31:0]   rd_status;
  logic          bram_portb_clk;
  logic [AW-1:0] bram_portb_addr;
  logic [DW-1:0] bram_portb_rddata;
  logic          bram_portb_en;
  logic [TW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;

  int total = 0;
  int bad   = 0;

  axis_bram_reader #(
    .AXIS_TDATA_WIDTH (TW),
    .BRAM_DATA_WIDTH  (DW),
    .BRAM_ADDR_WIDTH  (AW)
  ) dut (
    .aclk              (aclk),
    .areset            (areset),
    .rd_control        (rd_control),
    .rd_status         (rd_status),
    .bram_portb_clk    (bram_portb_clk),
    .bram_portb_addr   (bram_portb_addr),
    .bram_portb_rddata (bram_portb_rddata),
    .bram_portb_en     (bram_portb_en),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast)
  );

  // BRAM model, 1-cycle read latency
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge aclk) begin
    if (bram_portb_en) bram_portb_rddata <= mem[bram_portb_addr];
  end

  // scoreboard storage
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];
  int            got_cyc[$];

  // monitor
  logic          mon_clr = 1'b0;
  int            cyc = 0;
  int            rd_cnt = 0;
  int            beats = 0;
  int            max_out = 0;
  int            stall_err = 0;
  logic [AW-1:0] max_addr = '0;
  logic [AW-1:0] first_addr = '0;
  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_beat = '0;

  always @(negedge aclk) begin
    cyc = cyc + 1;
    if (mon_clr || areset) begin
      got_q.delete();
      got_cyc.delete();
      rd_cnt = 0; beats = 0; max_out = 0; stall_err = 0;
      max_addr = '0; first_addr = '0; prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_axis_tvalid || ({m_axis_tlast, m_axis_tdata} !== prev_beat)))
        stall_err = stall_err + 1;
      if (rd_cnt - beats > max_out) max_out = rd_cnt - beats;
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back({m_axis_tlast, m_axis_tdata});
        got_cyc.push_back(cyc);
        beats = beats + 1;
      end
      if (bram_portb_en) begin
        if (rd_cnt == 0) first_addr = bram_portb_addr;
        if (bram_portb_addr > max_addr) max_addr = bram_portb_addr;
        rd_cnt = rd_cnt + 1;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tlast, m_axis_tdata};
    end
  end

  // driver tasks
  task automatic clear_mon;
    mon_clr = 1'b1;
    @(negedge aclk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic start(input logic [15:0] len, input logic stop);
    @(posedge aclk); #1;
    rd_control = {len, 14'd0, stop, 1'b1};
  endtask

  task automatic go_idle;
    rd_control[0] = 1'b0;
    repeat (3) begin @(posedge aclk); #1; end
  endtask

  // mode 0: tready held 1; mode 1: tready toggles every cycle
  task automatic wait_done(input int budget, input int mode, output logic timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge aclk); #1;
      if (mode == 1) m_axis_tready = ~m_axis_tready;
      else           m_axis_tready = 1'b1;
      if (rd_status[0]) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset;
    #3;
    total++; if (rd_status !== 32'd0) begin bad++; $display("FAIL reset_status: got %h want 00000000", rd_status); end
    total++; if (bram_portb_en !== 1'b0) begin bad++; $display("FAIL reset_en: got %b want 0", bram_portb_en); end
    total++; if ({m_axis_tvalid, m_axis_tlast} !== 2'b00) begin bad++; $display("FAIL reset_axis: got valid/last %b want 00", {m_axis_tvalid, m_axis_tlast}); end
    total++; if (bram_portb_addr !== 4'd0) begin bad++; $display("FAIL reset_addr: got %h want 0", bram_portb_addr); end
    @(posedge aclk); #4;
    areset = 1'b0;
    @(posedge aclk); #1;
    total++; if ({rd_status[1:0], m_axis_tvalid} !== 3'b000) begin bad++; $display("FAIL idle_after_reset: got busy/done/valid %b want 000", {rd_status[1:0], m_axis_tvalid}); end
  endtask

  task automatic test_basic;
    logic to;
    for (int i = 0; i < 16; i++) mem[i] = 16'(i);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 32'(i)});
    m_axis_tready = 1'b1;
    clear_mon();
    start(16'd8, 1'b0);
    @(posedge aclk); #1;   // IDLE -> READ taken on this edge
    total++; if (rd_status[1:0] !== 2'b10) begin bad++; $display("FAIL basic_busy: got busy/done %b want 10", rd_status[1:0]); end
    @(posedge aclk); #1;
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b want 0", m_axis_tvalid); end
    @(posedge aclk); #1;
    total++; if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 32'd0}) begin bad++; $display("FAIL basic_latency: got valid=%b data=%h want valid=1 data=0", m_axis_tvalid, m_axis_tdata); end
    wait_done(40, 0, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL basic_timeout: got timeout=%b want 0", to); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL basic_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    if (got_cyc.size() == 8) begin
      total++; if (got_cyc[7] - got_cyc[0] != 7) begin bad++; $display("FAIL basic_throughput: got span %0d want 7", got_cyc[7] - got_cyc[0]); end
    end
    total++; if (rd_status !== {16'd8, 14'd0, 2'b01}) begin bad++; $display("FAIL basic_status: got %h want 00080001", rd_status); end
    repeat (3) begin @(posedge aclk); #1; end
    total++; if (rd_status[1:0] !== 2'b01) begin bad++; $display("FAIL basic_hold_done: got busy/done %b want 01", rd_status[1:0]); end
    rd_control[0] = 1'b0;
    @(posedge aclk); #1;
    total++; if (rd_status[1:0] !== 2'b00) begin bad++; $display("FAIL basic_back_idle: got busy/done %b want 00", rd_status[1:0]); end
    go_idle();
  endtask

  task automatic test_backpressure;
    logic to;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 32'(i)});
    m_axis_tready = 1'b1;
    clear_mon();
    start(16'd8, 1'b0);
    wait_done(80, 1, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL bp_timeout: got timeout=%b want 0", to); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    total++; if (stall_err != 0) begin bad++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err); end
    total++; if (max_out > 2) begin bad++; $display("FAIL bp_outstanding: got %0d want <=2", max_out); end
    total++; if (rd_status[31:16] !== 16'd8) begin bad++; $display("FAIL bp_words: got %0d want 8", rd_status[31:16]); end
    m_axis_tready = 1'b1;
    go_idle();
  endtask

  task automatic test_delimiter;
    logic to;
    for (int i = 0; i < 16; i++) mem[i] = 16'h1234;
    mem[0] = 16'h0001; mem[1] = 16'h8000; mem[2] = 16'h7FFF; mem[3] = 16'h0005;
    exp_q.delete();
    exp_q.push_back({1'b0, 32'h0000_0001});
    exp_q.push_back({1'b0, 32'hFFFF_8000});
    exp_q.push_back({1'b1, 32'h0000_7FFF});
    m_axis_tready = 1'b1;
    clear_mon();
    start(16'd16, 1'b1);
    wait_done(40, 0, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL delim_timeout: got timeout=%b want 0", to); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL delim_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL delim_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    total++; if (rd_status !== {16'd3, 14'd0, 2'b01}) begin bad++; $display("FAIL delim_status: got %h want 00030001", rd_status); end
    total++; if (max_addr > 4'd3) begin bad++; $display("FAIL delim_overread: got max addr %0d want <=3", max_addr); end
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL delim_trailing: got valid %b want 0", m_axis_tvalid); end
    go_idle();
  endtask

  task automatic test_delim_last;
    logic to;
    mem[0] = 16'h0010; mem[1] = 16'hFFFF; mem[2] = 16'h2000; mem[3] = 16'h7FFF;
    exp_q.delete();
    exp_q.push_back({1'b0, 32'h0000_0010});
    exp_q.push_back({1'b0, 32'hFFFF_FFFF});
    exp_q.push_back({1'b0, 32'h0000_2000});
    exp_q.push_back({1'b1, 32'h0000_7FFF});
    m_axis_tready = 1'b1;
    clear_mon();
    start(16'd4, 1'b1);
    wait_done(40, 0, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL dlast_timeout: got timeout=%b want 0", to); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL dlast_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL dlast_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    total++; if (rd_status[31:16] !== 16'd4) begin bad++; $display("FAIL dlast_words: got %0d want 4", rd_status[31:16]); end
    total++; if (rd_cnt != 4) begin bad++; $display("FAIL dlast_reads: got %0d reads want 4", rd_cnt); end
    go_idle();
  endtask

  task automatic test_full_space;
    logic to;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0100 + 16'(i);
    mem[5] = 16'h7FFF;  // ignored: stop_on_delim is off
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), (i == 5) ? 32'h0000_7FFF : 32'h0000_0100 + 32'(i)});
    m_axis_tready = 1'b1;
    clear_mon();
    start(16'd0, 1'b0);
    wait_done(60, 0, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL full_timeout: got timeout=%b want 0", to); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL full_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    repeat (2) begin @(posedge aclk); #1; end
    total++; if (rd_cnt != 16) begin bad++; $display("FAIL full_reads: got %0d reads want 16", rd_cnt); end
    total++; if (max_addr !== 4'd15) begin bad++; $display("FAIL full_max_addr: got %0d want 15", max_addr); end
    total++; if (rd_status !== {16'd16, 14'd0, 2'b01}) begin bad++; $display("FAIL full_status: got %h want 00100001", rd_status); end
    go_idle();
  endtask

  task automatic test_enable_drop;
    logic to;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0A00 + 16'(i);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 32'h0000_0A00 + 32'(i)});
    m_axis_tready = 1'b1;
    clear_mon();
    start(16'd8, 1'b0);
    repeat (3) begin @(posedge aclk); #1; end
    rd_control[0] = 1'b0;
    wait_done(40, 0, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL drop_timeout: got timeout=%b want 0", to); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL drop_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL drop_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    @(posedge aclk); #1;
    total++; if (rd_status[1:0] !== 2'b00) begin bad++; $display("FAIL drop_to_idle: got busy/done %b want 00", rd_status[1:0]); end
    clear_mon();
    start(16'd8, 1'b0);
    wait_done(40, 0, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL rearm_timeout: got timeout=%b want 0", to); end
    total++; if (first_addr !== 4'd0) begin bad++; $display("FAIL rearm_first_addr: got %0d want 0", first_addr); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rearm_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    go_idle();
  endtask

  task automatic test_async_reset;
    logic to;
    logic seen;
    m_axis_tready = 1'b1;
    clear_mon();
    start(16'd8, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge aclk); #1;
      seen = m_axis_tvalid;
    end
    total++; if ({m_axis_tvalid, bram_portb_en} !== 2'b11) begin bad++; $display("FAIL arst_precond: got valid/en %b want 11", {m_axis_tvalid, bram_portb_en}); end
    #2 areset = 1'b1;
    #1;
    total++; if ({m_axis_tvalid, bram_portb_en} !== 2'b00) begin bad++; $display("FAIL arst_axis_en: got valid/en %b want 00", {m_axis_tvalid, bram_portb_en}); end
    total++; if (rd_status !== 32'd0) begin bad++; $display("FAIL arst_status: got %h want 00000000", rd_status); end
    rd_control[0] = 1'b0;
    #2 areset = 1'b0;
    @(posedge aclk); #1;
    total++; if ({rd_status[1:0], m_axis_tvalid, bram_portb_en} !== 4'b0000 || bram_portb_addr !== 4'd0) begin
      bad++; $display("FAIL arst_idle: got busy/done/valid/en %b addr %0d want 0000 addr 0", {rd_status[1:0], m_axis_tvalid, bram_portb_en}, bram_portb_addr);
    end
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 32'h0000_0A00 + 32'(i)});
    clear_mon();
    start(16'd4, 1'b0);
    wait_done(40, 0, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL arst_restart_timeout: got timeout=%b want 0", to); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL arst_restart_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL arst_restart_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    go_idle();
  endtask

  initial begin
    areset        = 1'b1;
    rd_control    = 32'd0;
    m_axis_tready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_delimiter();
    test_delim_last();
    test_full_space();
    test_enable_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
